dp_ram_be_arb: RTL and testbench
================================

# dp_ram_be_arb

Parametrised true dual-port RAM with per-byte write enables, per-port request/grant handshakes, same-address collision arbitration and an optional post-reset zero-initialisation sequencer. It is the next-generation data/instruction memory for the SoC memory subsystem. Both the core and the debug/UART bridge connect to it directly, without an external arbiter. Storage is a generic inferred array, so the block is vendor-independent.

## Interface
Parameters:
- ADDR_WIDTH, 9, word address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration error otherwise)
- INIT_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = memory is usable immediately

Ports (x = a, b; identical per port):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- init_done_o  out  1  high once the block accepts requests
- req_x_i  in  1  access request
- gnt_x_o  out  1  request accepted this cycle (combinational)
- addr_x_i  in  ADDR_WIDTH  word address
- we_x_i  in  1  1 = write, 0 = read
- be_x_i  in  DATA_WIDTH/8  byte enables; writes only
- wdata_x_i  in  DATA_WIDTH  write data
- rvalid_x_o  out  1  read data valid, one cycle after a granted read
- rdata_x_o  out  DATA_WIDTH  read data; holds its last value between reads

## Operation
- Reset values: init_done_o=0, gnt_*=0, rvalid_*=0, rdata_*=0. Array contents are not reset.
- FSM states:
  - ST_INIT: entered on reset release when INIT_ON_RESET=1. Writes zero to word cnt, with cnt counting 0..DEPTH-1, one word per cycle. Goes to ST_READY after word DEPTH-1 is written.
  - With INIT_ON_RESET=0, reset releases directly into ST_READY.
  - ST_READY: init_done_o=1. The block stays here until reset.
- gnt_x_o is 0 in ST_INIT. Requesters must hold req/addr/we/be/wdata stable until granted.
- Arbitration in ST_READY:
  - gnt_x_o = req_x_i, except when both ports request the same address and at least one of them is a write.
  - In that case port A is granted and port B is stalled (gnt_b_o=0), unless forwarding is enabled (see Configuration).
  - Two reads of the same address are both granted.
- Writes: only bytes with be set are updated. A write with be=0 is granted and leaves memory unchanged. A write never asserts rvalid.
- Reads: data is captured into rdata_x_o and rvalid_x_o pulses for one cycle.
- Reset asserted mid-init: the counter restarts at 0 and the full init sequence reruns.

## Timing
- Write granted in cycle N: the array is updated at the end of cycle N.
- Read granted in cycle N: rvalid/rdata are presented in cycle N+1.
- Back-to-back write (N) then read (N+1) of the same address on either port returns the written data at N+2.
- One request per port per cycle, giving full throughput of two accesses per cycle when there is no collision.
- Init lasts exactly DEPTH cycles. init_done_o rises in the cycle after the last init write.

## Configuration
- DP_RAM_WR_FWD_EN defined:
  - A read colliding with a write on the other port is granted in the same cycle (write-first behaviour).
  - Its rdata is the old word with the written bytes, per be, replaced by the new wdata.
  - Write/write collisions still stall port B.
- DP_RAM_WR_FWD_EN undefined: every collision that involves a write stalls port B for that cycle.

## Structure
- Package dp_ram_pkg holds:
  - the state enum (ST_INIT, ST_READY)
  - the BYTE_W=8 constant
  - a function that merges a word and write data under byte enables
- Sub-module dp_ram_be_core is the raw two-port byte-enabled storage array, with no arbitration or reset.
- dp_ram_be_arb contains the FSM, init counter, arbitration, forwarding and read-valid registers.

## Test plan
- INIT_ON_RESET=1, ADDR_WIDTH=4, array pre-filled with 0xFFFFFFFF -> init_done_o rises 16 cycles after reset release. A read of address 15 then returns 0x00000000.
- Port A writes 0xAABBCCDD with be=0101 to address 3 (old content 0x11223344), then reads address 3 -> rdata_a_o=0x11BB33DD with rvalid_a_o one cycle after the grant.
- Both ports read address 7 in the same cycle -> both granted, and both rvalid pulse next cycle with identical data.
- Port A writes 0x12345678 to address 5 while port B reads address 5:
  - without DP_RAM_WR_FWD_EN -> gnt_b_o=0 that cycle, and B's read returns 0x12345678 one cycle later than unstalled.
  - with the macro -> gnt_b_o=1 and rdata_b_o=0x12345678 next cycle.
- Both ports write address 9 (A=0x1, B=0x2) -> A granted first and B the next cycle; a final read returns 0x2.
- rst_n asserted at init count 8 for 2 cycles -> all outputs return to their reset values, and init_done_o rises a full DEPTH cycles after the second release.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
package dp_ram_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  localparam int BYTE_W     = 8;
  // Widest word the merge helper handles; narrower callers zero-extend.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / BYTE_W;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++)
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    return res;
  endfunction

endpackage

// File: rtl/dp_ram_be_core.sv
// Raw two-port storage array with per-byte write enables and
// asynchronous read; no arbitration, no reset.
module dp_ram_be_core
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_a_i,
  input  logic [ADDR_WIDTH-1:0]    addr_a_i,
  input  logic [DATA_WIDTH/8-1:0]  be_a_i,
  input  logic [DATA_WIDTH-1:0]    wdata_a_i,
  output logic [DATA_WIDTH-1:0]    rdata_a_o,
  input  logic                     we_b_i,
  input  logic [ADDR_WIDTH-1:0]    addr_b_i,
  input  logic [DATA_WIDTH/8-1:0]  be_b_i,
  input  logic [DATA_WIDTH-1:0]    wdata_b_i,
  output logic [DATA_WIDTH-1:0]    rdata_b_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-granular writes; the arbiter never lets both ports write one word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we_a_i && be_a_i[i]) mem_q[addr_a_i][i*BYTE_W +: BYTE_W] <= wdata_a_i[i*BYTE_W +: BYTE_W];
      if (we_b_i && be_b_i[i]) mem_q[addr_b_i][i*BYTE_W +: BYTE_W] <= wdata_b_i[i*BYTE_W +: BYTE_W];
    end
  end

  assign rdata_a_o = mem_q[addr_a_i];
  assign rdata_b_o = mem_q[addr_b_i];

endmodule

// File: rtl/dp_ram_be_arb.sv
// Dual-port byte-enabled RAM with request/grant per port, same-address
// collision arbitration (port A wins) and optional zero-init after reset.
// Define DP_RAM_WR_FWD_EN to grant read/write collisions with write-first
// forwarding instead of stalling port B.
module dp_ram_be_arb
  import dp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_done_o,
  input  logic                     req_a_i,
  output logic                     gnt_a_o,
  input  logic [ADDR_WIDTH-1:0]    addr_a_i,
  input  logic                     we_a_i,
  input  logic [DATA_WIDTH/8-1:0]  be_a_i,
  input  logic [DATA_WIDTH-1:0]    wdata_a_i,
  output logic                     rvalid_a_o,
  output logic [DATA_WIDTH-1:0]    rdata_a_o,
  input  logic                     req_b_i,
  output logic                     gnt_b_o,
  input  logic [ADDR_WIDTH-1:0]    addr_b_i,
  input  logic                     we_b_i,
  input  logic [DATA_WIDTH/8-1:0]  be_b_i,
  input  logic [DATA_WIDTH-1:0]    wdata_b_i,
  output logic                     rvalid_b_o,
  output logic [DATA_WIDTH-1:0]    rdata_b_o
);
  localparam int BE_W = DATA_WIDTH / BYTE_W;
  localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

  if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("dp_ram_be_arb: DATA_WIDTH must be a multiple of 8 and at most MAX_DATA_W");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

  logic ready, init_wr, same_addr, stall_b, gnt_a, gnt_b, fwd_a, fwd_b;
  logic                  core_we_a;
  logic [ADDR_WIDTH-1:0] core_addr_a;
  logic [BE_W-1:0]       core_be_a;
  logic [DATA_WIDTH-1:0] core_wd_a, core_rd_a, core_rd_b;

  // State and init counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Init walks every word once, then parks in READY until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) state_d = ST_READY;
      end
      ST_READY: ;
      default: state_d = RST_STATE;
    endcase
  end

  // rst_n is folded in so that a READY reset state still shows idle outputs.
  assign ready   = (state_q == ST_READY) && rst_n;
  assign init_wr = (state_q == ST_INIT) && rst_n;

  assign same_addr = req_a_i && req_b_i && (addr_a_i == addr_b_i);
`ifdef DP_RAM_WR_FWD_EN
  assign stall_b = same_addr && we_a_i && we_b_i;
  assign fwd_b   = same_addr && we_a_i && !we_b_i;
  assign fwd_a   = same_addr && we_b_i && !we_a_i;
`else
  assign stall_b = same_addr && (we_a_i || we_b_i);
  assign fwd_b   = 1'b0;
  assign fwd_a   = 1'b0;
`endif
  assign gnt_a = ready && req_a_i;
  assign gnt_b = ready && req_b_i && !stall_b;

  // Port A of the array is borrowed by the init sequencer.
  assign core_we_a   = init_wr || (gnt_a && we_a_i);
  assign core_addr_a = init_wr ? cnt_q : addr_a_i;
  assign core_be_a   = init_wr ? '1 : be_a_i;
  assign core_wd_a   = init_wr ? '0 : wdata_a_i;

  dp_ram_be_core #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk       (clk),
    .we_a_i    (core_we_a),
    .addr_a_i  (core_addr_a),
    .be_a_i    (core_be_a),
    .wdata_a_i (core_wd_a),
    .rdata_a_o (core_rd_a),
    .we_b_i    (gnt_b && we_b_i),
    .addr_b_i  (addr_b_i),
    .be_b_i    (be_b_i),
    .wdata_b_i (wdata_b_i),
    .rdata_b_o (core_rd_b)
  );

  // Read capture: hold rdata between reads, merge in the other port's write on collision.
  always_comb begin
    rvalid_a_d = gnt_a && !we_a_i;
    rvalid_b_d = gnt_b && !we_b_i;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    if (rvalid_a_d)
      rdata_a_d = fwd_a ? DATA_WIDTH'(be_merge(MAX_DATA_W'(core_rd_a), MAX_DATA_W'(wdata_b_i),
                                               MAX_BE_W'(be_b_i)))
                        : core_rd_a;
    if (rvalid_b_d)
      rdata_b_d = fwd_b ? DATA_WIDTH'(be_merge(MAX_DATA_W'(core_rd_b), MAX_DATA_W'(wdata_a_i),
                                               MAX_BE_W'(be_a_i)))
                        : core_rd_b;
  end

  // Read-valid and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

  assign init_done_o = ready;
  assign gnt_a_o     = gnt_a;
  assign gnt_b_o     = gnt_b;
  assign rvalid_a_o  = rvalid_a_q;
  assign rvalid_b_o  = rvalid_b_q;
  assign rdata_a_o   = rdata_a_q;
  assign rdata_b_o   = rdata_b_q;

endmodule

// File: tb/tb_dp_ram_be_arb.sv
// Directed bench for dp_ram_be_arb (ADDR_WIDTH=4, 32-bit words, init on).
// A word-array model is stepped once per cycle and compared against every
// output; literal checks pin the model at the interesting points.
module tb_dp_ram_be_arb;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          req_a, gnt_a, we_a, rvalid_a;
  logic          req_b, gnt_b, we_b, rvalid_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [3:0]    be_a, be_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  dp_ram_be_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done_o(init_done),
    .req_a_i(req_a), .gnt_a_o(gnt_a), .addr_a_i(addr_a), .we_a_i(we_a), .be_a_i(be_a),
    .wdata_a_i(wdata_a), .rvalid_a_o(rvalid_a), .rdata_a_o(rdata_a),
    .req_b_i(req_b), .gnt_b_o(gnt_b), .addr_b_i(addr_b), .we_b_i(we_b), .be_b_i(be_b),
    .wdata_b_i(wdata_b), .rvalid_b_o(rvalid_b), .rdata_b_o(rdata_b)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int err = 0;

  // Model state
  logic [31:0] mem_m [DEPTH];
  int          init_left = DEPTH;
  logic        e_rva = 1'b0, e_rvb = 1'b0;
  logic [31:0] e_rda = '0, e_rdb = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Compare all outputs against the model, then advance the model over the coming edge.
  task automatic model_cycle();
    logic rdy, same, ga, gb;
    logic [31:0] ra, rb;
    if (!rst_n) begin
      e_rva = 1'b0; e_rvb = 1'b0; e_rda = '0; e_rdb = '0;
      init_left = DEPTH;
    end
    rdy  = rst_n && (init_left == 0);
    same = req_a && req_b && (addr_a == addr_b);
    ga   = rdy && req_a;
`ifdef DP_RAM_WR_FWD_EN
    gb   = rdy && req_b && !(same && we_a && we_b);
`else
    gb   = rdy && req_b && !(same && (we_a || we_b));
`endif
    chk("m_init_done", 32'(init_done), 32'(rdy));
    chk("m_gnt_a", 32'(gnt_a), 32'(ga));
    chk("m_gnt_b", 32'(gnt_b), 32'(gb));
    chk("m_rvalid_a", 32'(rvalid_a), 32'(e_rva));
    chk("m_rvalid_b", 32'(rvalid_b), 32'(e_rvb));
    chk("m_rdata_a", rdata_a, e_rda);
    chk("m_rdata_b", rdata_b, e_rdb);
    // A read sees any write granted to the same word in the same cycle.
    ra = mem_m[addr_a];
    rb = mem_m[addr_b];
    if (ga && gb && same && we_b && !we_a) ra = bmerge(ra, wdata_b, be_b);
    if (ga && gb && same && we_a && !we_b) rb = bmerge(rb, wdata_a, be_a);
    e_rva = ga && !we_a;
    e_rvb = gb && !we_b;
    if (e_rva) e_rda = ra;
    if (e_rvb) e_rdb = rb;
    if (ga && we_a) mem_m[addr_a] = bmerge(mem_m[addr_a], wdata_a, be_a);
    if (gb && we_b) mem_m[addr_b] = bmerge(mem_m[addr_b], wdata_b, be_b);
    if (rst_n && init_left > 0) begin
      mem_m[DEPTH - init_left] = '0;
      init_left--;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    req_a = r; we_a = w; addr_a = a; be_a = be; wdata_a = d;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    req_b = r; we_b = w; addr_b = a; be_b = be; wdata_b = d;
  endtask

  task automatic idle();
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
  endtask

  // Parallel, non-colliding traffic: {we_a,addr_a,be_a,wd_a, we_b,addr_b,be_b,wd_b}
  logic        tw_a [5] = '{1, 0, 1, 0, 0};
  logic [3:0]  ta_a [5] = '{10, 11, 12, 12, 13};
  logic [3:0]  tb_a [5] = '{4'hF, 4'h0, 4'b0110, 4'h0, 4'h0};
  logic [31:0] td_a [5] = '{32'hA0A0A0A0, 0, 32'h00CDEF00, 0, 0};
  logic        tw_b [5] = '{1, 0, 0, 1, 0};
  logic [3:0]  ta_b [5] = '{11, 10, 3, 13, 12};
  logic [3:0]  tb_b [5] = '{4'b1000, 4'h0, 4'h0, 4'hF, 4'h0};
  logic [31:0] td_b [5] = '{32'h5B000000, 0, 0, 32'h13131313, 0};

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    idle();
    rst_n = 1'b0;
    step(); step();
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_rdata_a", rdata_a, 32'h0);
    rst_n = 1'b1;
    repeat (DEPTH) step();
    chk("first_init_done", 32'(init_done), 32'd1);

    // Fill every word with ones using both ports at full throughput.
    for (int i = 0; i < 8; i++) begin
      set_a(1, 1, 4'(2*i), 4'hF, 32'hFFFFFFFF);
      set_b(1, 1, 4'(2*i+1), 4'hF, 32'hFFFFFFFF);
      step();
    end
    idle(); set_a(1, 0, 15, 0, 0); step(); idle();
    chk("prefill_rdata_15", rdata_a, 32'hFFFFFFFF);
    step();

    // Re-init with a read of word 15 held pending.
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    set_a(1, 0, 15, 0, 0);
    repeat (DEPTH-1) step();
    chk("init_done_15cyc", 32'(init_done), 32'd0);
    step();
    chk("init_done_16cyc", 32'(init_done), 32'd1);
    step(); idle();
    chk("init_rvalid_15", 32'(rvalid_a), 32'd1);
    chk("init_rdata_15", rdata_a, 32'h00000000);

    // Byte enables.
    set_a(1, 1, 3, 4'hF, 32'h11223344); step();
    set_a(1, 1, 3, 4'b0101, 32'hAABBCCDD); step();
    set_a(1, 0, 3, 0, 0); step(); idle();
    chk("be_rvalid", 32'(rvalid_a), 32'd1);
    chk("be_rdata", rdata_a, 32'h11BB33DD);
    set_a(1, 1, 3, 4'h0, 32'hFFFFFFFF); step();
    chk("be0_no_rvalid", 32'(rvalid_a), 32'd0);
    set_a(1, 0, 3, 0, 0); step(); idle();
    chk("be0_unchanged", rdata_a, 32'h11BB33DD);

    // Dual read of the same word.
    set_b(1, 1, 7, 4'hF, 32'hCAFEF00D); step(); idle();
    set_a(1, 0, 7, 0, 0); set_b(1, 0, 7, 0, 0);
    #1;
    chk("rr_gnt_a", 32'(gnt_a), 32'd1);
    chk("rr_gnt_b", 32'(gnt_b), 32'd1);
    step(); idle();
    chk("rr_rvalid_a", 32'(rvalid_a), 32'd1);
    chk("rr_rvalid_b", 32'(rvalid_b), 32'd1);
    chk("rr_rdata_a", rdata_a, 32'hCAFEF00D);
    chk("rr_rdata_b", rdata_b, 32'hCAFEF00D);

    // A writes, B reads the same word.
    set_a(1, 1, 5, 4'hF, 32'h12345678); set_b(1, 0, 5, 0, 0);
    #1;
`ifdef DP_RAM_WR_FWD_EN
    chk("wr_gnt_b", 32'(gnt_b), 32'd1);
    step(); idle();
`else
    chk("wr_gnt_b", 32'(gnt_b), 32'd0);
    step(); set_a(0, 0, 0, 0, 0);
    chk("wr_stall_rvalid_b", 32'(rvalid_b), 32'd0);
    step(); idle();
`endif
    chk("wr_rvalid_b", 32'(rvalid_b), 32'd1);
    chk("wr_rdata_b", rdata_b, 32'h12345678);

    // B writes low half, A reads the same word.
    set_b(1, 1, 5, 4'b0011, 32'h0000BEEF); set_a(1, 0, 5, 0, 0);
`ifdef DP_RAM_WR_FWD_EN
    step(); idle();
    chk("bw_ar_rdata_a", rdata_a, 32'h1234BEEF);
`else
    step(); set_a(0, 0, 0, 0, 0);
    chk("bw_ar_rdata_a", rdata_a, 32'h12345678);
    step(); idle();
`endif
    set_a(1, 0, 5, 0, 0); step(); idle();
    chk("bw_final", rdata_a, 32'h1234BEEF);

    // Write/write collision: A first, B next cycle.
    set_a(1, 1, 9, 4'hF, 32'h1); set_b(1, 1, 9, 4'hF, 32'h2);
    #1;
    chk("ww_gnt_a", 32'(gnt_a), 32'd1);
    chk("ww_gnt_b", 32'(gnt_b), 32'd0);
    step(); set_a(0, 0, 0, 0, 0);
    #1;
    chk("ww_gnt_b_next", 32'(gnt_b), 32'd1);
    step(); idle();
    set_a(1, 0, 9, 0, 0); step(); idle();
    chk("ww_final", rdata_a, 32'h2);

    // Parallel traffic on distinct words.
    for (int i = 0; i < 5; i++) begin
      set_a(1, tw_a[i], ta_a[i], tb_a[i], td_a[i]);
      set_b(1, tw_b[i], ta_b[i], tb_b[i], td_b[i]);
      step();
    end
    idle();
    chk("par_rdata_a", rdata_a, 32'h13131313);
    chk("par_rdata_b", rdata_b, 32'h00CDEF00);

    // Reset at init count 8, held two cycles.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    repeat (8) step();
    rst_n = 1'b0; set_a(1, 0, 8, 0, 0);
    #1;
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_gnt_a", 32'(gnt_a), 32'd0);
    chk("midrst_rdata_a", rdata_a, 32'h0);
    chk("midrst_rdata_b", rdata_b, 32'h0);
    step(); step(); rst_n = 1'b1;
    repeat (DEPTH-1) step();
    chk("midrst_done_15", 32'(init_done), 32'd0);
    step();
    chk("midrst_done_16", 32'(init_done), 32'd1);
    step(); idle();
    chk("midrst_rdata_8", rdata_a, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
